// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-master SRAM arbiter.
// Holds the sequencer state set and the counter sizing rule.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_TURN
  } state_e;

  typedef logic mid_t;

  localparam int DEF_ADDR_W = 20;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_RD_CYCLES = 2;
  localparam int DEF_WR_CYCLES = 3;
  localparam int DEF_TURN_CYCLES = 1;

  function automatic int cnt_w(
    input int rd,
    input int wr,
    input int turn
  );
    int m;
    m = 2;
    if (rd > m) m = rd;
    if (wr > m) m = wr;
    if (turn > m) m = turn;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter with a registered last-grant pointer.
// Out of reset the pointer names m1, so m0 wins the first tie.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      unique case (req)
        2'b11:   gnt = last ? 2'b01 : 2'b10;
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (|gnt) begin
      last <= gnt[1];
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-master SRAM arbiter and access sequencer.
// All io_sram_* outputs, done and rdata are registered.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int RD_CYCLES   = DEF_RD_CYCLES,
  parameter int WR_CYCLES   = DEF_WR_CYCLES,
  parameter int TURN_CYCLES = DEF_TURN_CYCLES
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [3:0]        m0_wmask,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [3:0]        m1_wmask,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_done,
  output logic              m1_done,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              io_sram_en,
  output logic              io_sram_re,
  output logic              io_sram_we,
  output logic [ADDR_W-1:0] io_sram_addr,
  output logic [DATA_W-1:0] io_sram_din,
  output logic [3:0]        io_sram_wmask,
  input  logic [DATA_W-1:0] io_sram_dout
);

  localparam int CW = cnt_w(RD_CYCLES, WR_CYCLES, TURN_CYCLES);
  localparam logic [CW-1:0] RD_LD = CW'(RD_CYCLES - 1);
  localparam logic [CW-1:0] WR_LD = CW'(WR_CYCLES - 1);
  localparam logic [CW-1:0] TN_LD =
    CW'(TURN_CYCLES > 0 ? TURN_CYCLES - 1 : 0);

  state_e            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  mid_t              own, own_n;
  logic [1:0]        gnt;
  logic [1:0]        done_n;
  logic              en_n, re_n, we_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] din_n;
  logic [3:0]        wmask_n;
  logic [DATA_W-1:0] rd0_n, rd1_n;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [3:0]        sel_wmask;

  rr_arbiter2 u_arb (
    .clk   (clock),
    .rst_n (reset_n),
    .en    (state == ST_IDLE),
    .req   ({m1_req, m0_req}),
    .gnt   (gnt)
  );

  assign m0_gnt    = gnt[0];
  assign m1_gnt    = gnt[1];
  assign sel_we    = gnt[1] ? m1_we    : m0_we;
  assign sel_addr  = gnt[1] ? m1_addr  : m0_addr;
  assign sel_wdata = gnt[1] ? m1_wdata : m0_wdata;
  assign sel_wmask = gnt[1] ? m1_wmask : m0_wmask;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    own_n   = own;
    en_n    = 1'b0;
    re_n    = 1'b0;
    we_n    = 1'b0;
    addr_n  = '0;
    din_n   = '0;
    wmask_n = '0;
    done_n  = 2'b00;
    rd0_n   = m0_rdata;
    rd1_n   = m1_rdata;
    unique case (state)
      ST_IDLE: begin
        if (|gnt) begin
          own_n  = gnt[1];
          en_n   = 1'b1;
          addr_n = sel_addr;
          if (sel_we) begin
            state_n = ST_WRITE;
            cnt_n   = WR_LD;
            we_n    = 1'b1;
            din_n   = sel_wdata;
            wmask_n = sel_wmask;
          end else begin
            state_n = ST_READ;
            cnt_n   = RD_LD;
            re_n    = 1'b1;
          end
        end
      end
      ST_READ: begin
        if (cnt == '0) begin
          state_n     = ST_IDLE;
          done_n[own] = 1'b1;
          if (own) rd1_n = io_sram_dout;
          else     rd0_n = io_sram_dout;
        end else begin
          cnt_n  = cnt - CW'(1);
          en_n   = 1'b1;
          re_n   = 1'b1;
          addr_n = io_sram_addr;
        end
      end
      ST_WRITE: begin
        if (cnt == '0) begin
          done_n[own] = 1'b1;
          if (own) rd1_n = '0;
          else     rd0_n = '0;
          state_n = (TURN_CYCLES == 0) ? ST_IDLE : ST_TURN;
          cnt_n   = TN_LD;
        end else begin
          cnt_n   = cnt - CW'(1);
          en_n    = 1'b1;
          we_n    = 1'b1;
          addr_n  = io_sram_addr;
          din_n   = io_sram_din;
          wmask_n = io_sram_wmask;
        end
      end
      ST_TURN: begin
        if (cnt == '0) state_n = ST_IDLE;
        else           cnt_n   = cnt - CW'(1);
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      own           <= 1'b0;
      io_sram_en    <= 1'b0;
      io_sram_re    <= 1'b0;
      io_sram_we    <= 1'b0;
      io_sram_addr  <= '0;
      io_sram_din   <= '0;
      io_sram_wmask <= '0;
      m0_done       <= 1'b0;
      m1_done       <= 1'b0;
      m0_rdata      <= '0;
      m1_rdata      <= '0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      own           <= own_n;
      io_sram_en    <= en_n;
      io_sram_re    <= re_n;
      io_sram_we    <= we_n;
      io_sram_addr  <= addr_n;
      io_sram_din   <= din_n;
      io_sram_wmask <= wmask_n;
      m0_done       <= done_n[0];
      m1_done       <= done_n[1];
      m0_rdata      <= rd0_n;
      m1_rdata      <= rd1_n;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios plus a random
// two-master run checked against a transaction-level model.
module tb_sram_arbiter;

  localparam int AW = 20;
  localparam int DW = 32;
  localparam int RD = 2;
  localparam int WR = 3;
  localparam int TN = 1;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic [3:0]    m0_wmask, m1_wmask;
  logic          m0_gnt, m1_gnt, m0_done, m1_done;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          io_sram_en, io_sram_re, io_sram_we;
  logic [AW-1:0] io_sram_addr;
  logic [DW-1:0] io_sram_din;
  logic [3:0]    io_sram_wmask;
  logic [DW-1:0] io_sram_dout;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  sram_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .RD_CYCLES(RD),
    .WR_CYCLES(WR), .TURN_CYCLES(TN)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wmask(m0_wmask),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
    .m0_done(m0_done), .m1_done(m1_done),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .io_sram_en(io_sram_en), .io_sram_re(io_sram_re),
    .io_sram_we(io_sram_we), .io_sram_addr(io_sram_addr),
    .io_sram_din(io_sram_din), .io_sram_wmask(io_sram_wmask),
    .io_sram_dout(io_sram_dout)
  );

  // SRAM model: seeded contents plus a record of bus writes
  function automatic logic [31:0] seed_data(input logic [7:0] a);
    if (a == 8'h10) return 32'hDEADBEEF;
    return {a, ~a, a ^ 8'h5A, 8'hC3} ^ 32'h9E3779B9;
  endfunction

  function automatic logic [31:0] merge(
    input logic [31:0] o,
    input logic [31:0] n,
    input logic [3:0]  m
  );
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++)
      if (m[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  logic [31:0] mem [256];
  logic        wrt [256];
  logic        mem_clr = 1'b1;

  function automatic logic [31:0] cur(input logic [7:0] a);
    return wrt[a] ? mem[a] : seed_data(a);
  endfunction

  always_comb begin
    io_sram_dout = '0;
    if (io_sram_en && io_sram_re)
      io_sram_dout = cur(io_sram_addr[7:0]);
  end

  always @(posedge clock) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) wrt[i] <= 1'b0;
    end else if (io_sram_en && io_sram_we) begin
      mem[io_sram_addr[7:0]] <= merge(cur(io_sram_addr[7:0]),
                                      io_sram_din, io_sram_wmask);
      wrt[io_sram_addr[7:0]] <= 1'b1;
    end
  end

  // Reference memory: updated in grant order, one transaction at a time
  logic [31:0] ref_mem [int];

  function automatic logic [31:0] ref_get(input logic [7:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : seed_data(a);
  endfunction

  task automatic nxt;
    @(posedge clock);
    #1;
  endtask

  task automatic clr_in;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0; m0_wmask = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_wmask = '0;
  endtask

  task automatic apply_reset;
    clr_in();
    reset_n = 0;
    mem_clr = 1;
    ref_mem.delete();
    repeat (2) nxt();
    reset_n = 1;
    mem_clr = 0;
  endtask

  task automatic test_reset;
    clr_in();
    reset_n = 0;
    repeat (2) nxt();
    n_cmp++;
    if ({io_sram_en, io_sram_re, io_sram_we} !== 3'b000) begin
      n_bad++;
      $display("FAIL rst_strobes: got %b want 000",
               {io_sram_en, io_sram_re, io_sram_we});
    end
    n_cmp++;
    if (io_sram_addr !== '0 || io_sram_din !== '0 ||
        io_sram_wmask !== '0) begin
      n_bad++;
      $display("FAIL rst_bus: addr %0h din %0h mask %0h want 0",
               io_sram_addr, io_sram_din, io_sram_wmask);
    end
    n_cmp++;
    if ({m0_done, m1_done} !== 2'b00) begin
      n_bad++;
      $display("FAIL rst_done: got %b want 00", {m0_done, m1_done});
    end
    n_cmp++;
    if (m0_rdata !== '0 || m1_rdata !== '0) begin
      n_bad++;
      $display("FAIL rst_rdata: got %0h/%0h want 0/0",
               m0_rdata, m1_rdata);
    end
    reset_n = 1;
    mem_clr = 0;
    nxt();
  endtask

  task automatic test_read_m0;
    nxt();
    m0_req = 1; m0_we = 0; m0_addr = 20'h00010;
    #1;
    n_cmp++;
    if ({m1_gnt, m0_gnt} !== 2'b01) begin
      n_bad++;
      $display("FAIL rd_gnt: got %b want 01", {m1_gnt, m0_gnt});
    end
    for (int k = 1; k <= 3; k++) begin
      nxt();
      m0_req = 0;
      #1;
      if (k <= 2) begin
        n_cmp++;
        if ({io_sram_en, io_sram_re, io_sram_we} !== 3'b110 ||
            io_sram_addr !== 20'h00010 || m0_done !== 1'b0) begin
          n_bad++;
          $display("FAIL rd_bus%0d: ere %b addr %0h done %b want 110 10 0",
                   k, {io_sram_en, io_sram_re, io_sram_we},
                   io_sram_addr, m0_done);
        end
      end else begin
        n_cmp++;
        if (m0_done !== 1'b1 || m0_rdata !== 32'hDEADBEEF) begin
          n_bad++;
          $display("FAIL rd_done: done %b rdata %0h want 1 deadbeef",
                   m0_done, m0_rdata);
        end
        n_cmp++;
        if (m1_done !== 1'b0 || io_sram_en !== 1'b0) begin
          n_bad++;
          $display("FAIL rd_other: m1_done %b en %b want 0 0",
                   m1_done, io_sram_en);
        end
      end
    end
  endtask

  task automatic test_write_m1;
    logic [31:0] exp;
    nxt();
    m1_req = 1; m1_we = 1; m1_addr = 20'h00020;
    m1_wdata = 32'h12345678; m1_wmask = 4'b0011;
    #1;
    n_cmp++;
    if ({m1_gnt, m0_gnt} !== 2'b10) begin
      n_bad++;
      $display("FAIL wr_gnt: got %b want 10", {m1_gnt, m0_gnt});
    end
    for (int k = 1; k <= 3; k++) begin
      nxt();
      m1_req = 0;
      #1;
      n_cmp++;
      if ({io_sram_en, io_sram_we, io_sram_re} !== 3'b110 ||
          io_sram_din !== 32'h12345678 || io_sram_wmask !== 4'b0011 ||
          io_sram_addr !== 20'h00020 || m1_done !== 1'b0) begin
        n_bad++;
        $display("FAIL wr_bus%0d: ewr %b din %0h mask %b addr %0h done %b",
                 k, {io_sram_en, io_sram_we, io_sram_re}, io_sram_din,
                 io_sram_wmask, io_sram_addr, m1_done);
      end
    end
    nxt();
    m0_req = 1; m0_we = 0; m0_addr = 20'h00020;
    #1;
    n_cmp++;
    if (m1_done !== 1'b1 || m1_rdata !== '0) begin
      n_bad++;
      $display("FAIL wr_done: done %b rdata %0h want 1 0",
               m1_done, m1_rdata);
    end
    n_cmp++;
    if (io_sram_en !== 1'b0 || m0_gnt !== 1'b0) begin
      n_bad++;
      $display("FAIL wr_turn: en %b m0_gnt %b want 0 0",
               io_sram_en, m0_gnt);
    end
    nxt();
    #1;
    n_cmp++;
    if (m0_gnt !== 1'b1 || io_sram_en !== 1'b0) begin
      n_bad++;
      $display("FAIL wr_next_gnt: m0_gnt %b en %b want 1 0",
               m0_gnt, io_sram_en);
    end
    nxt();
    m0_req = 0;
    #1;
    n_cmp++;
    if ({io_sram_en, io_sram_re} !== 2'b11) begin
      n_bad++;
      $display("FAIL wr_rd_start: got %b want 11",
               {io_sram_en, io_sram_re});
    end
    nxt();
    nxt();
    exp = merge(seed_data(8'h20), 32'h12345678, 4'b0011);
    n_cmp++;
    if (m0_done !== 1'b1 || m0_rdata !== exp) begin
      n_bad++;
      $display("FAIL wr_readback: done %b rdata %0h want 1 %0h",
               m0_done, m0_rdata, exp);
    end
  endtask

  task automatic test_back_to_back;
    int k;
    int win;
    logic [7:0] a [2];
    logic [7:0] prev_a;
    apply_reset();
    k = 0;
    prev_a = '0;
    a[0] = 8'($urandom); a[1] = 8'($urandom);
    m0_req = 1; m0_we = 0; m0_addr = {12'h0, a[0]};
    m1_req = 1; m1_we = 0; m1_addr = {12'h0, a[1]};
    for (int c = 0; c < 60 && k < 6; c++) begin
      #1;
      win = -1;
      if (m0_gnt && m1_gnt) begin
        n_cmp++; n_bad++;
        $display("FAIL b2b_both: got 11 want one-hot");
      end else if (m0_gnt) win = 0;
      else if (m1_gnt) win = 1;
      if (win >= 0) begin
        n_cmp++;
        if (win != (k % 2)) begin
          n_bad++;
          $display("FAIL b2b_order%0d: got m%0d want m%0d", k, win, k % 2);
        end
        if (k > 0) begin
          n_cmp++;
          if ({m1_done, m0_done} !== (win == 0 ? 2'b10 : 2'b01)) begin
            n_bad++;
            $display("FAIL b2b_done%0d: got %b want other master",
                     k, {m1_done, m0_done});
          end
          n_cmp++;
          if ((win == 0 ? m1_rdata : m0_rdata) !== seed_data(prev_a)) begin
            n_bad++;
            $display("FAIL b2b_rdata%0d: got %0h want %0h", k,
                     win == 0 ? m1_rdata : m0_rdata, seed_data(prev_a));
          end
        end
        prev_a = a[win];
        k++;
      end
      nxt();
      if (win >= 0) begin
        a[win] = 8'($urandom);
        if (win == 0) m0_addr = {12'h0, a[0]};
        else          m1_addr = {12'h0, a[1]};
      end
    end
    n_cmp++;
    if (k < 6) begin
      n_bad++;
      $display("FAIL b2b_timeout: got %0d grants want 6", k);
    end
    clr_in();
    repeat (5) nxt();
  endtask

  task automatic test_reset_mid_write;
    m0_req = 1; m0_we = 1; m0_addr = 20'h00030;
    m0_wdata = 32'hA5A5_5A5A; m0_wmask = 4'hF;
    #1;
    n_cmp++;
    if (m0_gnt !== 1'b1) begin
      n_bad++;
      $display("FAIL rw_gnt: got %b want 1", m0_gnt);
    end
    nxt();
    m0_req = 0;
    m1_req = 1; m1_we = 0; m1_addr = 20'h00031;
    #1;
    n_cmp++;
    if (m1_gnt !== 1'b0 || {io_sram_en, io_sram_we} !== 2'b11) begin
      n_bad++;
      $display("FAIL rw_busy: m1_gnt %b ew %b want 0 11",
               m1_gnt, {io_sram_en, io_sram_we});
    end
    nxt();
    m0_req = 1;
    reset_n = 0;
    #1;
    n_cmp++;
    if ({io_sram_en, io_sram_we} !== 2'b00 || io_sram_addr !== '0) begin
      n_bad++;
      $display("FAIL rw_async: ew %b addr %0h want 00 0",
               {io_sram_en, io_sram_we}, io_sram_addr);
    end
    for (int k = 0; k < 3; k++) begin
      nxt();
      #1;
      n_cmp++;
      if ({m0_done, m1_done} !== 2'b00) begin
        n_bad++;
        $display("FAIL rw_nodone%0d: got %b want 00",
                 k, {m0_done, m1_done});
      end
    end
    nxt();
    reset_n = 1;
    #1;
    n_cmp++;
    if ({m1_gnt, m0_gnt} !== 2'b01) begin
      n_bad++;
      $display("FAIL rw_regrant: got %b want 01", {m1_gnt, m0_gnt});
    end
    nxt();
    m0_req = 0;
    repeat (3) nxt();
    #1;
    n_cmp++;
    if ({m1_done, m0_done} !== 2'b01) begin
      n_bad++;
      $display("FAIL rw_done: got %b want 01", {m1_done, m0_done});
    end
    clr_in();
    repeat (4) nxt();
  endtask

  typedef struct {
    bit          v;
    bit          we;
    logic [7:0]  a;
    logic [31:0] wd;
    logic [3:0]  wm;
  } rq_t;

  task automatic test_random;
    rq_t         pend [2];
    rq_t         act;
    bit          act_v;
    int          act_id, act_t, act_n;
    logic [31:0] act_rd;
    logic [31:0] held [2];
    int          free_at, last, eg, c;
    bit          in_acc;
    logic [1:0]  exp_g, exp_d;
    apply_reset();
    pend[0].v = 0; pend[1].v = 0;
    act_v = 0; act_id = 0; act_t = 0; act_n = 0; act_rd = '0;
    act = pend[0];
    held[0] = '0; held[1] = '0;
    free_at = 0; last = 1;
    for (c = 0; c < 400; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (!pend[m].v && $urandom_range(0, 2) == 0) begin
          pend[m].v  = 1;
          pend[m].we = 1'($urandom_range(0, 1));
          pend[m].a  = 8'($urandom_range(0, 15));
          pend[m].wd = $urandom;
          pend[m].wm = 4'($urandom);
        end
      end
      m0_req = pend[0].v; m0_we = pend[0].we;
      m0_addr = {12'h0, pend[0].a};
      m0_wdata = pend[0].wd; m0_wmask = pend[0].wm;
      m1_req = pend[1].v; m1_we = pend[1].we;
      m1_addr = {12'h0, pend[1].a};
      m1_wdata = pend[1].wd; m1_wmask = pend[1].wm;
      #1;
      eg = -1;
      if (c >= free_at) begin
        if (pend[0].v && pend[1].v) eg = 1 - last;
        else if (pend[0].v) eg = 0;
        else if (pend[1].v) eg = 1;
      end
      exp_g = (eg < 0) ? 2'b00 : (eg == 0 ? 2'b01 : 2'b10);
      n_cmp++;
      if ({m1_gnt, m0_gnt} !== exp_g) begin
        n_bad++;
        $display("FAIL rnd_gnt c%0d: got %b want %b",
                 c, {m1_gnt, m0_gnt}, exp_g);
      end
      in_acc = act_v && c >= act_t + 1 && c <= act_t + act_n;
      n_cmp++;
      if (io_sram_en !== in_acc) begin
        n_bad++;
        $display("FAIL rnd_en c%0d: got %b want %b", c, io_sram_en, in_acc);
      end
      if (in_acc) begin
        n_cmp++;
        if ({io_sram_re, io_sram_we} !== (act.we ? 2'b01 : 2'b10) ||
            io_sram_addr !== {12'h0, act.a}) begin
          n_bad++;
          $display("FAIL rnd_bus c%0d: rw %b addr %0h want we=%0d %0h",
                   c, {io_sram_re, io_sram_we}, io_sram_addr,
                   act.we, act.a);
        end
        if (act.we) begin
          n_cmp++;
          if (io_sram_din !== act.wd || io_sram_wmask !== act.wm) begin
            n_bad++;
            $display("FAIL rnd_wdata c%0d: din %0h mask %b want %0h %b",
                     c, io_sram_din, io_sram_wmask, act.wd, act.wm);
          end
        end
      end
      exp_d = 2'b00;
      if (act_v && c == act_t + act_n + 1) begin
        exp_d = (act_id == 0) ? 2'b01 : 2'b10;
        held[act_id] = act.we ? 32'h0 : act_rd;
        act_v = 0;
      end
      n_cmp++;
      if ({m1_done, m0_done} !== exp_d) begin
        n_bad++;
        $display("FAIL rnd_done c%0d: got %b want %b",
                 c, {m1_done, m0_done}, exp_d);
      end
      n_cmp++;
      if (m0_rdata !== held[0] || m1_rdata !== held[1]) begin
        n_bad++;
        $display("FAIL rnd_rdata c%0d: got %0h/%0h want %0h/%0h",
                 c, m0_rdata, m1_rdata, held[0], held[1]);
      end
      if (eg >= 0) begin
        act    = pend[eg];
        act_v  = 1;
        act_id = eg;
        act_t  = c;
        act_n  = act.we ? WR : RD;
        act_rd = ref_get(act.a);
        if (act.we) ref_mem[int'(act.a)] = merge(act_rd, act.wd, act.wm);
        free_at = c + act_n + 1 + (act.we ? TN : 0);
        last = eg;
        pend[eg].v = 0;
      end
      nxt();
    end
    clr_in();
    repeat (6) nxt();
  endtask

  initial begin
    clr_in();
    test_reset();
    test_read_m0();
    test_write_m1();
    test_back_to_back();
    test_reset_mid_write();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Two-master arbiter and access sequencer for the single external SRAM port. Typical masters: instruction fetch on m0, load/store on m1.
- Accepts requests on per-master req/gnt handshakes and arbitrates round-robin.
- Holds each SRAM access for a fixed number of cycles, captures read data, and returns a one-cycle done pulse.
- Drives the io_sram_* bus of the SRAM tristate wrapper directly; all bus outputs are registered.

Parameters:
- ADDR_W, 20, SRAM word address width.
- DATA_W, 32, data width.
- RD_CYCLES, 2, cycles sram_en/sram_re are held per read; must be >=1.
- WR_CYCLES, 3, cycles sram_en/sram_we are held per write; must be >=1.
- TURN_CYCLES, 1, idle bus cycles after a write before the next access (0 skips TURN).

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- m0_req, m1_req  in  1  request; held stable with its payload until gnt.
- m0_we, m1_we  in  1  1=write, 0=read.
- m0_addr, m1_addr  in  ADDR_W  word address.
- m0_wdata, m1_wdata  in  DATA_W  write data.
- m0_wmask, m1_wmask  in  4  byte-enable mask, active high.
- m0_gnt, m1_gnt  out  1  combinational; request accepted this cycle.
- m0_done, m1_done  out  1  one-cycle completion pulse.
- m0_rdata, m1_rdata  out  DATA_W  read data; valid with done on reads, 0 on writes.
- io_sram_en, io_sram_re, io_sram_we  out  1  bus strobes.
- io_sram_addr  out  ADDR_W  bus address.
- io_sram_din  out  DATA_W  write data.
- io_sram_wmask  out  4  byte mask.
- io_sram_dout  in  DATA_W  read data from the wrapper.

Behaviour:
- Reset: state IDLE, counter 0, rr pointer favours m0. Every registered output is 0, including strobes, addr, din, wmask, done and rdata. Reset takes effect asynchronously, so strobes fall immediately. An access in progress is aborted, gives no done pulse, and must be reissued.
- States are IDLE, READ, WRITE and TURN.
- IDLE:
  - gnt is asserted only in IDLE. With one req, that master is granted. With both, the master other than the last-granted one wins.
  - On grant, latch id, we, addr, wdata and wmask. Load the counter with RD_CYCLES-1 or WR_CYCLES-1. Go to READ or WRITE.
- READ:
  - io_sram_en=1, io_sram_re=1, io_sram_we=0, io_sram_din=0, io_sram_wmask=0, addr held.
  - On the final cycle (counter==0), register io_sram_dout, then go to IDLE.
- WRITE:
  - io_sram_en=1, io_sram_we=1, io_sram_re=0; addr, din and wmask held for all WR_CYCLES.
  - After the final cycle, go to TURN, or to IDLE if TURN_CYCLES==0.
- TURN: all strobes 0 and din=0 for TURN_CYCLES, then IDLE.
- Latency, counting the grant cycle as T:
  - Strobes are active T+1..T+N, where N is RD_CYCLES or WR_CYCLES.
  - The owner's done pulses at T+N+1, together with rdata for reads.
  - A read done coincides with IDLE, so a new grant is allowed in that same cycle.
- rdata is held until that master's next done.
- done is never asserted for the non-owner; gnt and done are never both high for different masters' same access.
- wmask=0 writes still run the full cycle and pulse done.
- Request changes before gnt are a protocol violation. The block does not check for them.
- Counter width is clog2 of max(RD_CYCLES, WR_CYCLES, TURN_CYCLES, 2). There is no wrap-around beyond reload.

Decomposition:
- Package sram_arb_pkg holds the state enum (IDLE/READ/WRITE/TURN), master-id type (1 bit), default cycle constants and the counter-width function.
- Sub-module rr_arbiter2: 2-input round-robin with a registered last-grant pointer, grant-enable input and one-hot grant output.

Test Plan:
- m0 read addr 0x00010, model returns 0xDEADBEEF -> m0_gnt at T; en/re high T+1..T+2 with addr 0x00010; m0_done at T+3 with m0_rdata=0xDEADBEEF; m1_done stays 0.
- m1 write addr 0x00020, data 0x12345678, mask 0011 -> en/we high T+1..T+3 with din/mask stable; m1_done at T+4; strobes 0 at T+4 (TURN); next gnt no earlier than T+5.
- Both req held continuously, all reads -> grants alternate m0, m1, m0, m1; first grant m0; no back-to-back same-master grant.
- m0 req arrives while m1 read is busy -> m0_gnt low until IDLE; granted in the cycle m1_done pulses.
- Write followed by queued read -> a bus cycle with io_sram_en=0 separates the last we cycle from the first re cycle.
- reset_n low during second WRITE cycle -> io_sram_en/we drop to 0 without waiting for a clock edge; no done pulse; after release, pending req granted from IDLE with m0 priority.
